// File: rtl/pwl_seq_pkg.sv
// Shared types for the synth ALU sequencer: op codes, register indices,
// host address field widths and the debug snapshot struct.
package pwl_seq_pkg;

  localparam int ADDR_CH_W  = 2;
  localparam int ADDR_REG_W = 4;
  localparam int ADDR_W     = ADDR_CH_W + ADDR_REG_W;
  localparam int DBG_W      = 8;

  typedef enum logic [2:0] {
    OP_NOP    = 3'd0,
    OP_PHASE  = 3'd1,
    OP_SWEEP0 = 3'd2,
    OP_SWEEP1 = 3'd3,
    OP_OUT    = 3'd4,
    OP_WRITE  = 3'd5,
    OP_READ   = 3'd6
  } op_e;

  localparam logic [ADDR_REG_W-1:0] PERIOD     = 4'd0;
  localparam logic [ADDR_REG_W-1:0] AMP        = 4'd1;
  localparam logic [ADDR_REG_W-1:0] PWM_OFFSET = 4'd2;
  localparam logic [ADDR_REG_W-1:0] SLOPE0     = 4'd3;
  localparam logic [ADDR_REG_W-1:0] SLOPE1     = 4'd4;
  localparam logic [ADDR_REG_W-1:0] SWEEP0     = 4'd5;
  localparam logic [ADDR_REG_W-1:0] SWEEP1     = 4'd6;
  localparam logic [ADDR_REG_W-1:0] MODE       = 4'd7;
  localparam logic [ADDR_REG_W-1:0] PHASE      = 4'd8;

  typedef enum logic [1:0] {
    H_IDLE  = 2'd0,
    H_ISSUE = 2'd1,
    H_ACK   = 2'd2
  } host_st_e;

  typedef struct packed {
    logic [DBG_W-1:0] slot;
    logic [DBG_W-1:0] sweep_cnt;
    host_st_e         host_st;
  } seq_dbg_t;

  // Low two slot bits select which per-channel update runs in that slot.
  function automatic op_e update_op(input logic [1:0] k);
    case (k)
      2'd0:    return OP_PHASE;
      2'd1:    return OP_SWEEP0;
      2'd2:    return OP_SWEEP1;
      default: return OP_OUT;
    endcase
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Host register-access port and ALU command bus of the sequencer.
interface alu_sequencer_if
  import pwl_seq_pkg::*;
#(
  parameter int DATA_W = 13
);
  // Host: host_req rises with host_we/addr/wdata stable and stays high until a
  // one-cycle host_ack; host_rdata is valid with that ack. ALU: alu_op/alu_ch
  // are meaningful only while alu_valid=1, and alu_rdata answers a READ in the
  // same cycle it is on the bus.
  logic                  host_req;
  logic                  host_we;
  logic [ADDR_W-1:0]     host_addr;
  logic [DATA_W-1:0]     host_wdata;
  logic                  host_ack;
  logic [DATA_W-1:0]     host_rdata;
  logic                  alu_valid;
  op_e                   alu_op;
  logic [ADDR_CH_W-1:0]  alu_ch;
  logic [ADDR_REG_W-1:0] alu_reg;
  logic [DATA_W-1:0]     alu_wdata;
  logic [DATA_W-1:0]     alu_rdata;

  modport master (
    output host_req, host_we, host_addr, host_wdata, alu_rdata,
    input  host_ack, host_rdata, alu_valid, alu_op, alu_ch, alu_reg, alu_wdata
  );

  modport slave (
    input  host_req, host_we, host_addr, host_wdata, alu_rdata,
    output host_ack, host_rdata, alu_valid, alu_op, alu_ch, alu_reg, alu_wdata
  );

endinterface

// File: rtl/alu_sequencer_host_port.sv
// Host access FSM: grants a request in a host slot, then walks through the
// ALU issue cycle and the ack cycle, capturing read data on the way.
module alu_sequencer_host_port
  import pwl_seq_pkg::*;
#(
  parameter int DATA_W = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_slot,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [DATA_W-1:0] alu_rdata,
  output logic              grant,
  output logic              host_ack,
  output logic [DATA_W-1:0] host_rdata,
  output host_st_e          state
);

  logic we_q;

  // Requests are ignored in both ISSUE and ACK, so one request gets one grant.
  assign grant = host_slot && host_req && (state == H_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= H_IDLE;
      we_q       <= 1'b0;
      host_ack   <= 1'b0;
      host_rdata <= '0;
    end else begin
      host_ack <= 1'b0;
      case (state)
        H_IDLE: begin
          if (grant) begin
            state <= H_ISSUE;
            we_q  <= host_we;
          end
        end
        H_ISSUE: begin
          state    <= H_ACK;
          host_ack <= 1'b1;
          if (!we_q) host_rdata <= alu_rdata;
        end
        H_ACK:   state <= H_IDLE;
        default: state <= H_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Frame scheduler for the shared synth ALU: per-channel update slots first,
// remaining slots (and all of en=0 time) go to the host register port.
module alu_sequencer
  import pwl_seq_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int FRAME_CYCLES = 32,
  parameter int SWEEP_DIV    = 4,
  parameter int DATA_W       = 13
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_enable,
  alu_sequencer_if.slave    bus,
  output logic              frame_done,
  output seq_dbg_t          dbg
);

  localparam int UPD_SLOTS = NUM_CH * 4;
  localparam int SLOT_W    = $clog2(FRAME_CYCLES);
  localparam int SW_W      = (SWEEP_DIV > 1) ? $clog2(SWEEP_DIV) : 1;

  logic [SLOT_W-1:0]    slot;
  logic [SW_W-1:0]      sweep_cnt;
  logic                 upd_slot;
  logic                 last_slot;
  logic                 grant;
  logic                 stall;
  logic                 ch_on;
  logic                 issue_upd;
  logic [ADDR_CH_W-1:0] upd_ch;
  logic [1:0]           upd_k;
  host_st_e             host_st;

  assign upd_slot  = en && (int'(slot) < UPD_SLOTS);
  assign last_slot = (int'(slot) == FRAME_CYCLES - 1);
  assign upd_ch    = ADDR_CH_W'(slot >> 2);
  assign upd_k     = slot[1:0];
  assign ch_on     = ch_enable[upd_ch];
  assign issue_upd = upd_slot && ch_on &&
                     ((upd_k == 2'd0) || (upd_k == 2'd3) || (sweep_cnt == '0));

  // A grant in the last host slot takes slot 0's bus position, so the
  // counter holds one cycle and the whole update schedule slips by one.
  assign stall = grant && en && last_slot;

  alu_sequencer_host_port #(
    .DATA_W(DATA_W)
  ) u_host_port (
    .clk       (clk),
    .rst_n     (rst_n),
    .host_slot (!upd_slot),
    .host_req  (bus.host_req),
    .host_we   (bus.host_we),
    .alu_rdata (bus.alu_rdata),
    .grant     (grant),
    .host_ack  (bus.host_ack),
    .host_rdata(bus.host_rdata),
    .state     (host_st)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot      <= '0;
      sweep_cnt <= '0;
    end else if (!en) begin
      slot <= '0;
    end else if (!stall) begin
      if (last_slot) begin
        slot      <= '0;
        sweep_cnt <= (int'(sweep_cnt) == SWEEP_DIV - 1) ? '0 : sweep_cnt + 1'b1;
      end else begin
        slot <= slot + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_valid <= 1'b0;
      bus.alu_op    <= OP_NOP;
      bus.alu_ch    <= '0;
      bus.alu_reg   <= '0;
      bus.alu_wdata <= '0;
      frame_done    <= 1'b0;
    end else begin
      bus.alu_valid <= 1'b0;
      bus.alu_op    <= OP_NOP;
      bus.alu_ch    <= '0;
      bus.alu_reg   <= '0;
      bus.alu_wdata <= '0;
      frame_done    <= upd_slot && (int'(slot) == UPD_SLOTS - 1);
      if (grant) begin
        bus.alu_valid <= 1'b1;
        bus.alu_op    <= bus.host_we ? OP_WRITE : OP_READ;
        bus.alu_ch    <= bus.host_addr[ADDR_W-1:ADDR_REG_W];
        bus.alu_reg   <= bus.host_addr[ADDR_REG_W-1:0];
        bus.alu_wdata <= bus.host_wdata;
      end else if (issue_upd) begin
        bus.alu_valid <= 1'b1;
        bus.alu_op    <= update_op(upd_k);
        bus.alu_ch    <= upd_ch;
      end
    end
  end

  assign dbg = '{slot: DBG_W'(slot), sweep_cnt: DBG_W'(sweep_cnt), host_st: host_st};

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: per-cycle expected bus records are queued from the
// frame schedule plus host overlays, then popped against the DUT each cycle.
module tb_alu_sequencer;
  import pwl_seq_pkg::*;

  localparam int W = 38;
  localparam logic [W-1:0] ACK_BIT = 38'h1 << 13;
  localparam logic [W-1:0] RD_M    = 38'h1FFF;
  localparam logic [W-1:0] WD_M    = 38'h1FFF << 15;
  localparam logic [W-1:0] RG_M    = 38'hF << 28;
  localparam logic [W-1:0] CH_M    = 38'h3 << 32;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ch_enable;
  logic       frame_done;
  seq_dbg_t   dbg;
  logic [12:0] rd_val;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  alu_sequencer_if #(.DATA_W(13)) bus ();

  alu_sequencer #(
    .NUM_CH(4), .FRAME_CYCLES(32), .SWEEP_DIV(4), .DATA_W(13)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ch_enable (ch_enable),
    .bus       (bus),
    .frame_done(frame_done),
    .dbg       (dbg)
  );

  // ALU stand-in: answers READ with the value the current scenario chose.
  assign bus.alu_rdata = (bus.alu_op == OP_READ) ? rd_val : 13'h1555;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- record helpers ----------------
  function automatic logic [W-1:0] rec(input logic v, input logic [2:0] op,
      input logic [1:0] ch, input logic [3:0] rg, input logic [12:0] wd,
      input logic fd, input logic ack, input logic [12:0] rd);
    return {v, op, ch, rg, wd, fd, ack, rd};
  endfunction

  function automatic logic [W-1:0] act_rec();
    return rec(bus.alu_valid, bus.alu_op, bus.alu_ch, bus.alu_reg, bus.alu_wdata,
               frame_done, bus.host_ack, bus.host_rdata);
  endfunction

  // Fields that carry meaning for a given expected record.
  function automatic logic [W-1:0] care(input logic [W-1:0] e);
    logic [2:0] op;
    op = e[36:34];
    if (!e[37]) return ~(CH_M | RG_M | WD_M);
    if (op >= 3'd1 && op <= 3'd4) return ~(RG_M | WD_M);
    return '1;
  endfunction

  // Expected bus for consecutive decision slots starting at absolute slot 'start'.
  task automatic push_slots(input int start, input int n, input logic [3:0] mask,
                            input logic [12:0] rd);
    for (int j = start; j < start + n; j++) begin
      int f, sl, ch, k;
      logic v;
      f = j / 32; sl = j % 32; ch = sl / 4; k = sl % 4;
      v = 1'b0;
      if (sl < 16) v = mask[ch[1:0]] && (k == 0 || k == 3 || (f % 4) == 0);
      exp_q.push_back(rec(v, v ? 3'(k + 1) : 3'd0, v ? 2'(ch) : 2'd0, 4'd0, 13'd0,
                          sl == 15, 1'b0, rd));
    end
  endtask

  task automatic set_rd(input int from, input logic [12:0] val);
    for (int j = from; j < exp_q.size(); j++)
      exp_q[j] = (exp_q[j] & ~RD_M) | W'(val);
  endtask

  task automatic host_start(input logic we, input logic [5:0] addr, input logic [12:0] wd);
    bus.host_req   = 1'b1;
    bus.host_we    = we;
    bus.host_addr  = addr;
    bus.host_wdata = wd;
  endtask

  task automatic apply_reset();
    en = 1'b0; ch_enable = 4'h0; rd_val = 13'h0;
    bus.host_req = 1'b0; bus.host_we = 1'b0; bus.host_addr = 6'h0; bus.host_wdata = 13'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [W-1:0] a;
    apply_reset();
    a = act_rec(); checks++;
    if (a !== '0) begin failures++; $display("FAIL reset_outputs act=%h exp=0", a); end
    checks++;
    if (dbg !== '0) begin failures++; $display("FAIL reset_dbg act=%h exp=0", dbg); end
    en = 1'b1; ch_enable = 4'hF;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    a = act_rec(); checks++;
    if (a !== '0) begin failures++; $display("FAIL async_reset_outputs act=%h exp=0", a); end
    checks++;
    if (dbg.slot !== 8'd0) begin failures++; $display("FAIL async_reset_slot act=%0d exp=0", dbg.slot); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frames();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 160, 4'hF, 13'd0);
    for (int i = 0; i < 160; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'hF; end
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL frames idx=%0d act=%h exp=%h", i, a, e);
      end
    end
  endtask

  task automatic test_ch_mask();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 64, 4'b0101, 13'd0);
    for (int i = 0; i < 64; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'b0101; end
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL ch_mask idx=%0d act=%h exp=%h", i, a, e);
      end
    end
  endtask

  task automatic test_host_write();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 40, 4'hF, 13'd0);
    exp_q[20] = rec(1'b1, OP_WRITE, 2'd2, 4'd1, 13'h1ABC, 1'b0, 1'b0, 13'd0);
    exp_q[21] = exp_q[21] | ACK_BIT;
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'hF; end
      if (i == 20) host_start(1'b1, 6'h21, 13'h1ABC);
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL host_write idx=%0d act=%h exp=%h", i, a, e);
      end
      if (bus.host_ack) bus.host_req = 1'b0;
    end
  endtask

  task automatic test_host_read_wait();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 40, 4'hF, 13'd0);
    exp_q[16] = rec(1'b1, OP_READ, 2'd1, 4'hA, 13'd0, 1'b0, 1'b0, 13'd0);
    exp_q[17] = exp_q[17] | ACK_BIT;
    set_rd(17, 13'h0F0F);
    for (int i = 0; i < 40; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'hF; end
      if (i == 3) begin rd_val = 13'h0F0F; host_start(1'b0, 6'h1A, 13'd0); end
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL host_read_wait idx=%0d act=%h exp=%h", i, a, e);
      end
      if (bus.host_ack) bus.host_req = 1'b0;
    end
  endtask

  task automatic test_last_slot();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 32, 4'hF, 13'd0);
    exp_q[31] = rec(1'b1, OP_READ, 2'd2, 4'd7, 13'd0, 1'b0, 1'b0, 13'd0);
    exp_q.push_back(rec(1'b0, OP_NOP, 2'd0, 4'd0, 13'd0, 1'b0, 1'b1, 13'd0));
    push_slots(32, 64, 4'hF, 13'd0);
    set_rd(32, 13'h0ABC);
    for (int i = 0; i < 97; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'hF; end
      if (i == 31) begin rd_val = 13'h0ABC; host_start(1'b0, 6'h27, 13'd0); end
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL last_slot idx=%0d act=%h exp=%h", i, a, e);
      end
      if (bus.host_ack) bus.host_req = 1'b0;
    end
  endtask

  task automatic test_en_drop();
    logic [W-1:0] a, e;
    apply_reset();
    exp_q.delete();
    push_slots(0, 7, 4'hF, 13'd0);
    for (int j = 7; j <= 40; j++)
      exp_q.push_back(rec(1'b0, OP_NOP, 2'd0, 4'd0, 13'd0, 1'b0, 1'b0, 13'd0));
    exp_q[9]  = rec(1'b1, OP_READ, 2'd1, 4'd2, 13'd0, 1'b0, 1'b0, 13'd0);
    exp_q[10] = exp_q[10] | ACK_BIT;
    exp_q[20] = rec(1'b1, OP_WRITE, 2'd0, 4'd8, 13'h0155, 1'b0, 1'b0, 13'd0);
    exp_q[21] = exp_q[21] | ACK_BIT;
    exp_q[40] = rec(1'b1, OP_READ, 2'd3, 4'hF, 13'd0, 1'b0, 1'b0, 13'd0);
    set_rd(10, 13'h0777);
    for (int i = 0; i <= 40; i++) begin
      if (i == 0) begin en = 1'b1; ch_enable = 4'hF; end
      if (i == 7) en = 1'b0;
      if (i == 9) begin rd_val = 13'h0777; host_start(1'b0, 6'h12, 13'd0); end
      if (i == 20) host_start(1'b1, 6'h08, 13'h0155);
      if (i == 40) begin rd_val = 13'h1111; host_start(1'b0, 6'h3F, 13'd0); end
      @(negedge clk);
      e = exp_q.pop_front(); a = act_rec(); checks++;
      if ((a & care(e)) !== (e & care(e))) begin
        failures++; $display("FAIL en_drop idx=%0d act=%h exp=%h", i, a, e);
      end
      if (bus.host_ack) bus.host_req = 1'b0;
    end
    // READ is on the bus now; reset drops it before its ack.
    rst_n = 1'b0; bus.host_req = 1'b0;
    #1;
    a = act_rec(); checks++;
    if (a !== '0) begin failures++; $display("FAIL reset_mid_grant act=%h exp=0", a); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      a = act_rec(); checks++;
      if (a !== '0) begin failures++; $display("FAIL no_ack_after_reset idx=%0d act=%h exp=0", i, a); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    test_reset();
    test_frames();
    test_ch_mask();
    test_host_write();
    test_host_read_wait();
    test_last_slot();
    test_en_drop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
